block_axi_bridge: RTL and testbench
===================================

BLOCK_AXI_BRIDGE -- requirements
Module: block_axi_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64, meaning byte-address width.
REQ-002 SHALL have parameter BLOCK_WIDTH, default 512, meaning cache-block width in bits.
REQ-003 SHALL have parameter BEAT_WIDTH, default 64, meaning AXI data width; beats per block N = BLOCK_WIDTH/BEAT_WIDTH (8).
REQ-004 SHALL have port i_clk, input, 1, meaning the single clock.
REQ-005 SHALL have port i_arst, input, 1, meaning asynchronous active-high reset.
REQ-006 SHALL have port i_axi_write_start, input, 1, meaning a block write-back is requested; held high until o_axi_done.
REQ-007 SHALL have port i_axi_read_start, input, 1, meaning a block refill is requested; held high until o_axi_done.
REQ-008 SHALL have port i_axi_addr, input, ADDR_WIDTH, meaning the block byte address.
REQ-009 SHALL have port i_data_block, input, BLOCK_WIDTH, meaning write-back data.
REQ-010 SHALL have port o_axi_done, output, 1, meaning a one-cycle completion pulse.
REQ-011 SHALL have port o_data_block, output, BLOCK_WIDTH, meaning refill data.
REQ-012 SHALL have ports o_arvalid (output, 1), i_arready (input, 1) and o_araddr (output, ADDR_WIDTH), meaning the AXI read-address channel.
REQ-013 SHALL have ports i_rvalid (input, 1), o_rready (output, 1), i_rdata (input, BEAT_WIDTH) and i_rlast (input, 1), meaning the AXI read-data channel.
REQ-014 SHALL have ports o_awvalid (output, 1), i_awready (input, 1) and o_awaddr (output, ADDR_WIDTH), meaning the AXI write-address channel.
REQ-015 SHALL have ports o_wvalid (output, 1), i_wready (input, 1), o_wdata (output, BEAT_WIDTH) and o_wlast (output, 1), meaning the AXI write-data channel.
REQ-016 SHALL have ports i_bvalid (input, 1) and o_bready (output, 1), meaning the AXI write-response channel.
REQ-017 SHALL run every burst as INCR, size = log2(BEAT_WIDTH/8), len = N-1; these constants are tied off outside this block.

Function
REQ-018 SHALL implement the FSM states IDLE, AR, R, AW, W, B and DONE.
REQ-019 SHALL, in IDLE, move to AW when i_axi_write_start is high, else to AR when i_axi_read_start is high; write takes priority when both are high.
REQ-020 SHALL capture i_axi_addr on leaving IDLE, with bits [log2(BLOCK_WIDTH/8)-1:0] forced to 0, and SHALL capture i_data_block when the write is accepted.
REQ-021 SHALL hold o_arvalid/o_awvalid high with a stable address only in AR/AW, and SHALL move to R/W on the cycle a valid and its ready are both high.
REQ-022 SHALL hold o_rready high only in R, and SHALL store beat k into o_data_block[k*BEAT_WIDTH +: BEAT_WIDTH] on each rvalid&rready; k counts 0..N-1 and starts at 0.
REQ-023 SHALL leave R for DONE on the beat where k = N-1; if i_rlast disagrees with k, the counter SHALL decide.
REQ-024 SHALL drive beat k of the captured block on o_wdata with o_wvalid high in W, advance k on wvalid&wready, and assert o_wlast only when k = N-1.
REQ-025 SHALL move to B after the last W handshake, hold o_bready high in B, and move to DONE on i_bvalid.
REQ-026 SHALL pulse o_axi_done for exactly one cycle in DONE and then return to IDLE; start inputs SHALL be ignored during DONE.
REQ-027 SHALL keep o_data_block stable outside R, retaining the last refill; partial updates inside R are permitted.
REQ-028 SHALL allow zero wait states, so that a read completes in 1 (AR) + N (R) + 1 (DONE) cycles minimum.

Reset
REQ-029 SHALL, on i_arst asserted at any time including mid-burst, go to IDLE and clear k, o_axi_done, all valid/ready outputs, o_wlast, o_data_block, and both captured registers.
REQ-030 SHALL start no transaction while i_arst is high.

Configuration
REQ-031 SHALL, with BLOCK_AXI_BRIDGE_RESP_CHECK_EN defined, add inputs i_rresp[1:0] and i_bresp[1:0] and output o_axi_error; o_axi_error SHALL be high alongside o_axi_done when any beat of the transaction had resp != 0, and SHALL reset to 0.
REQ-032 SHALL, without BLOCK_AXI_BRIDGE_RESP_CHECK_EN, omit those ports and ignore responses.

Verification
REQ-033 SHALL cover: read_start, addr=0x1234, ready always 1, rdata beat k = k+1 -> araddr=0x1200, done on cycle 10, o_data_block[63:0]=1 and [511:448]=8.
REQ-034 SHALL cover: write_start, block=beat k value 0xA0+k, wready low on every other cycle -> 8 wdata beats in order, wlast only with 0xA7, done one cycle after bvalid.
REQ-035 SHALL cover: write_start and read_start both high -> AW issued first, no AR before done.
REQ-036 SHALL cover: i_arst pulsed after R beat 3 -> all outputs 0 next cycle, then a new read completes normally.
REQ-037 SHALL cover: arready held low for 5 cycles -> arvalid and araddr stable throughout.
REQ-038 SHALL cover: with RESP_CHECK_EN, rresp=2 on beat 5 -> o_axi_error=1 with o_axi_done.

Source files
------------

// File: rtl/block_axi_bridge.sv
// block_axi_bridge: moves one cache block to/from AXI as an N-beat INCR burst.
// The FSM issues AR->R for a refill, or AW->W->B for a write-back, then pulses done.
// Optional build macro BLOCK_AXI_BRIDGE_RESP_CHECK_EN adds rresp/bresp inputs and
// an o_axi_error flag reported alongside o_axi_done.
module block_axi_bridge #(
    parameter int unsigned ADDR_WIDTH  = 64,
    parameter int unsigned BLOCK_WIDTH = 512,
    parameter int unsigned BEAT_WIDTH  = 64
) (
    input  logic                   i_clk,
    input  logic                   i_arst,
    input  logic                   i_axi_write_start,
    input  logic                   i_axi_read_start,
    input  logic [ADDR_WIDTH-1:0]  i_axi_addr,
    input  logic [BLOCK_WIDTH-1:0] i_data_block,
    output logic                   o_axi_done,
    output logic [BLOCK_WIDTH-1:0] o_data_block,
    output logic                   o_arvalid,
    input  logic                   i_arready,
    output logic [ADDR_WIDTH-1:0]  o_araddr,
    input  logic                   i_rvalid,
    output logic                   o_rready,
    input  logic [BEAT_WIDTH-1:0]  i_rdata,
    input  logic                   i_rlast,
    output logic                   o_awvalid,
    input  logic                   i_awready,
    output logic [ADDR_WIDTH-1:0]  o_awaddr,
    output logic                   o_wvalid,
    input  logic                   i_wready,
    output logic [BEAT_WIDTH-1:0]  o_wdata,
    output logic                   o_wlast,
    input  logic                   i_bvalid,
    output logic                   o_bready
`ifdef BLOCK_AXI_BRIDGE_RESP_CHECK_EN
    ,
    input  logic [1:0]             i_rresp,
    input  logic [1:0]             i_bresp,
    output logic                   o_axi_error
`endif
);

    localparam int unsigned N    = BLOCK_WIDTH / BEAT_WIDTH;
    localparam int unsigned CW   = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned OFFS = $clog2(BLOCK_WIDTH / 8);
    localparam logic [CW-1:0] KMAX = CW'(N - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_AW,
        ST_W,
        ST_B,
        ST_DONE
    } state_t;

    state_t                  state_q;
    logic [CW-1:0]           k_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [ADDR_WIDTH-1:0]   addr_d;
    logic [BEAT_WIDTH-1:0]   wr_q [N];
    logic [BEAT_WIDTH-1:0]   rd_q [N];
    logic [BEAT_WIDTH-1:0]   wblk_in [N];
    logic                    done_q;
    logic                    arvalid_q;
    logic                    rready_q;
    logic                    awvalid_q;
    logic                    wvalid_q;
    logic                    wlast_q;
    logic                    bready_q;

    // The beat counter alone decides the end of a read burst; rlast is not consulted.
    logic unused_rlast;
    assign unused_rlast = i_rlast;

    // Block-align the request address by clearing the in-block byte offset
    always_comb begin
        addr_d = i_axi_addr;
        addr_d[OFFS-1:0] = '0;
    end

    // Beat-wise views of the write-back input and the refill output
    for (genvar g = 0; g < N; g++) begin : g_beats
        assign wblk_in[g] = i_data_block[g*BEAT_WIDTH +: BEAT_WIDTH];
        assign o_data_block[g*BEAT_WIDTH +: BEAT_WIDTH] = rd_q[g];
    end

    // Transaction FSM with registered handshake outputs
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state_q   <= ST_IDLE;
            k_q       <= '0;
            addr_q    <= '0;
            wr_q      <= '{default: '0};
            rd_q      <= '{default: '0};
            done_q    <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            wlast_q   <= 1'b0;
            bready_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_axi_write_start) begin
                        state_q   <= ST_AW;
                        addr_q    <= addr_d;
                        wr_q      <= wblk_in;
                        awvalid_q <= 1'b1;
                    end else if (i_axi_read_start) begin
                        state_q   <= ST_AR;
                        addr_q    <= addr_d;
                        arvalid_q <= 1'b1;
                    end
                end
                ST_AR: begin
                    if (i_arready) begin
                        state_q   <= ST_R;
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        k_q       <= '0;
                    end
                end
                ST_R: begin
                    if (i_rvalid) begin
                        rd_q[k_q] <= i_rdata;
                        if (k_q == KMAX) begin
                            state_q  <= ST_DONE;
                            rready_q <= 1'b0;
                            done_q   <= 1'b1;
                            k_q      <= '0;
                        end else begin
                            k_q <= k_q + CW'(1);
                        end
                    end
                end
                ST_AW: begin
                    if (i_awready) begin
                        state_q   <= ST_W;
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b1;
                        k_q       <= '0;
                        wlast_q   <= (N == 1);
                    end
                end
                ST_W: begin
                    if (i_wready) begin
                        if (k_q == KMAX) begin
                            state_q  <= ST_B;
                            wvalid_q <= 1'b0;
                            wlast_q  <= 1'b0;
                            bready_q <= 1'b1;
                            k_q      <= '0;
                        end else begin
                            k_q     <= k_q + CW'(1);
                            wlast_q <= ((k_q + CW'(1)) == KMAX);
                        end
                    end
                end
                ST_B: begin
                    if (i_bvalid) begin
                        state_q  <= ST_DONE;
                        bready_q <= 1'b0;
                        done_q   <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_axi_done = done_q;
    assign o_arvalid  = arvalid_q;
    assign o_araddr   = addr_q;
    assign o_rready   = rready_q;
    assign o_awvalid  = awvalid_q;
    assign o_awaddr   = addr_q;
    assign o_wvalid   = wvalid_q;
    assign o_wdata    = wr_q[k_q];
    assign o_wlast    = wlast_q;
    assign o_bready   = bready_q;

`ifdef BLOCK_AXI_BRIDGE_RESP_CHECK_EN
    logic err_acc_q;
    logic err_q;
    logic beat_bad;
    logic to_done;

    assign beat_bad = (rready_q && i_rvalid && (i_rresp != 2'b00)) ||
                      (bready_q && i_bvalid && (i_bresp != 2'b00));
    assign to_done  = ((state_q == ST_R) && i_rvalid && (k_q == KMAX)) ||
                      ((state_q == ST_B) && i_bvalid);

    // Sticky per-transaction error, presented in the same cycle as the done pulse
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            err_acc_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if (state_q == ST_IDLE) begin
                err_acc_q <= 1'b0;
            end else if (beat_bad) begin
                err_acc_q <= 1'b1;
            end
            err_q <= to_done && (err_acc_q || beat_bad);
        end
    end

    assign o_axi_error = err_q;
`endif

endmodule

// File: tb/tb_block_axi_bridge.sv
// Self-checking bench for block_axi_bridge: acts as an AXI slave and compares
// against block-level expectations derived from the burst rules.
module tb_block_axi_bridge;

    localparam int AW = 64;
    localparam int BW = 512;
    localparam int DW = 64;
    localparam int NB = BW / DW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          i_arst;
    logic          i_axi_write_start, i_axi_read_start;
    logic [AW-1:0] i_axi_addr;
    logic [BW-1:0] i_data_block;
    logic          o_axi_done;
    logic [BW-1:0] o_data_block;
    logic          o_arvalid, i_arready;
    logic [AW-1:0] o_araddr;
    logic          i_rvalid, o_rready, i_rlast;
    logic [DW-1:0] i_rdata;
    logic          o_awvalid, i_awready;
    logic [AW-1:0] o_awaddr;
    logic          o_wvalid, i_wready, o_wlast;
    logic [DW-1:0] o_wdata;
    logic          i_bvalid, o_bready;
`ifdef BLOCK_AXI_BRIDGE_RESP_CHECK_EN
    logic [1:0]    i_rresp, i_bresp;
    logic          o_axi_error;
`endif

    block_axi_bridge #(
        .ADDR_WIDTH (AW),
        .BLOCK_WIDTH(BW),
        .BEAT_WIDTH (DW)
    ) dut (
        .i_clk            (clk),
        .i_arst           (i_arst),
        .i_axi_write_start(i_axi_write_start),
        .i_axi_read_start (i_axi_read_start),
        .i_axi_addr       (i_axi_addr),
        .i_data_block     (i_data_block),
        .o_axi_done       (o_axi_done),
        .o_data_block     (o_data_block),
        .o_arvalid        (o_arvalid),
        .i_arready        (i_arready),
        .o_araddr         (o_araddr),
        .i_rvalid         (i_rvalid),
        .o_rready         (o_rready),
        .i_rdata          (i_rdata),
        .i_rlast          (i_rlast),
        .o_awvalid        (o_awvalid),
        .i_awready        (i_awready),
        .o_awaddr         (o_awaddr),
        .o_wvalid         (o_wvalid),
        .i_wready         (i_wready),
        .o_wdata          (o_wdata),
        .o_wlast          (o_wlast),
        .i_bvalid         (i_bvalid),
        .o_bready         (o_bready)
`ifdef BLOCK_AXI_BRIDGE_RESP_CHECK_EN
        ,
        .i_rresp          (i_rresp),
        .i_bresp          (i_bresp),
        .o_axi_error      (o_axi_error)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Reference state: last completed refill (cleared by reset)
    logic [BW-1:0] model_rblk;
    int            err_beat = -1;

    // Observations collected by the slave driver
    bit            obs_done, obs_aborted, obs_ar_unstable, obs_aw_unstable, obs_done_after, obs_err;
    int            obs_done_cyc, obs_first_ar, obs_first_aw, obs_ar_cnt, obs_bvalid_cyc;
    logic [AW-1:0] obs_araddr, obs_awaddr;
    logic [DW-1:0] obs_wdata [$];
    bit            obs_wlast [$];

    function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
        return a & ~64'h3F;
    endfunction

    function automatic logic [BW-1:0] rand_block();
        logic [BW-1:0] b;
        for (int i = 0; i < BW / 32; i++) b[i*32 +: 32] = $urandom();
        return b;
    endfunction

    task automatic idle_inputs();
        i_axi_write_start = 1'b0;
        i_axi_read_start  = 1'b0;
        i_arready = 1'b0; i_rvalid = 1'b0; i_rdata = '0; i_rlast = 1'b0;
        i_awready = 1'b0; i_wready = 1'b0; i_bvalid = 1'b0;
`ifdef BLOCK_AXI_BRIDGE_RESP_CHECK_EN
        i_rresp = 2'd0; i_bresp = 2'd0;
`endif
    endtask

    // AXI slave driver: cycle 1 is the first cycle after start is presented.
    task automatic run_txn(input bit wr, input bit rd, input logic [AW-1:0] addr,
                           input logic [BW-1:0] wblk, input logic [BW-1:0] rblk,
                           input int ar_delay, input int aw_delay, input int rmode,
                           input int wmode, input int b_delay, input int abort_beats);
        int aw_cnt = 0, b_cnt = 0, rbeat = 0;
        bit wr_tog = 1'b0;
        obs_done = 0; obs_aborted = 0; obs_ar_unstable = 0; obs_aw_unstable = 0;
        obs_done_after = 0; obs_err = 0;
        obs_done_cyc = 0; obs_first_ar = 0; obs_first_aw = 0; obs_ar_cnt = 0; obs_bvalid_cyc = -1;
        obs_araddr = '0; obs_awaddr = '0;
        obs_wdata.delete(); obs_wlast.delete();
        @(negedge clk);
        idle_inputs();
        i_axi_write_start = wr;
        i_axi_read_start  = rd;
        i_axi_addr        = addr;
        i_data_block      = wblk;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            if (o_axi_done) begin
                obs_done = 1; obs_done_cyc = c;
`ifdef BLOCK_AXI_BRIDGE_RESP_CHECK_EN
                obs_err = o_axi_error;
`endif
                break;
            end
            if (o_arvalid) begin
                obs_ar_cnt++;
                if (obs_first_ar == 0) begin obs_first_ar = c; obs_araddr = o_araddr; end
                else if (o_araddr !== obs_araddr) obs_ar_unstable = 1;
            end
            if (o_awvalid) begin
                aw_cnt++;
                if (obs_first_aw == 0) begin obs_first_aw = c; obs_awaddr = o_awaddr; end
                else if (o_awaddr !== obs_awaddr) obs_aw_unstable = 1;
            end
            i_arready = o_arvalid && (obs_ar_cnt > ar_delay);
            i_awready = o_awvalid && (aw_cnt > aw_delay);
            i_rvalid  = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            i_rdata   = (rbeat < NB) ? rblk[rbeat*DW +: DW] : '0;
            i_rlast   = (rbeat == NB - 1);
`ifdef BLOCK_AXI_BRIDGE_RESP_CHECK_EN
            i_rresp   = (rbeat == err_beat) ? 2'd2 : 2'd0;
`endif
            if (wmode == 0) i_wready = 1'b1;
            else if (wmode == 1) begin wr_tog = ~wr_tog; i_wready = wr_tog; end
            else i_wready = 1'($urandom_range(0, 1));
            if (o_wvalid && i_wready) begin
                obs_wdata.push_back(o_wdata);
                obs_wlast.push_back(o_wlast);
            end
            if (o_bready) begin
                b_cnt++;
                i_bvalid = (b_cnt > b_delay);
                if (i_bvalid) obs_bvalid_cyc = c;
            end else begin
                i_bvalid = 1'b0;
            end
            if (o_rready && i_rvalid) begin
                rbeat++;
                if (abort_beats != 0 && rbeat == abort_beats) begin
                    @(posedge clk);
                    #2;
                    obs_aborted = 1;
                    break;
                end
            end
        end
        if (!obs_aborted) begin
            idle_inputs();
            @(negedge clk);
            obs_done_after = o_axi_done;
        end
    endtask

    task automatic test_reset();
        i_arst = 1'b1;
        idle_inputs();
        i_axi_addr = '0; i_data_block = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({o_arvalid, o_rready, o_awvalid, o_wvalid, o_wlast, o_bready, o_axi_done} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0000000",
                     {o_arvalid, o_rready, o_awvalid, o_wvalid, o_wlast, o_bready, o_axi_done});
        end
        checks++;
        if (o_data_block !== '0 || o_araddr !== '0) begin
            errors++;
            $display("FAIL reset_data: got block=%h araddr=%h expected 0", o_data_block, o_araddr);
        end
        i_arst = 1'b0;
        model_rblk = '0;
    endtask

    task automatic test_read_basic();
        logic [BW-1:0] rblk;
        for (int k = 0; k < NB; k++) rblk[k*DW +: DW] = 64'(k + 1);
        run_txn(0, 1, 64'h1234, '0, rblk, 0, 0, 0, 0, 0, 0);
        model_rblk = rblk;
        checks++;
        if (!obs_done || obs_done_cyc != 10) begin
            errors++;
            $display("FAIL read_basic_latency: got done=%0d cycle=%0d expected cycle 10", obs_done, obs_done_cyc);
        end
        checks++;
        if (obs_araddr !== 64'h1200) begin
            errors++;
            $display("FAIL read_basic_araddr: got %h expected %h", obs_araddr, 64'h1200);
        end
        checks++;
        if (o_data_block[63:0] !== 64'd1 || o_data_block[511:448] !== 64'd8) begin
            errors++;
            $display("FAIL read_basic_ends: got lo=%h hi=%h expected 1 and 8", o_data_block[63:0], o_data_block[511:448]);
        end
        checks++;
        if (o_data_block !== model_rblk) begin
            errors++;
            $display("FAIL read_basic_block: got %h expected %h", o_data_block, model_rblk);
        end
        checks++;
        if (obs_done_after !== 1'b0) begin
            errors++;
            $display("FAIL read_basic_done_width: got done high for 2 cycles, expected 1");
        end
    endtask

    task automatic test_write_basic();
        logic [BW-1:0] wblk;
        logic [AW-1:0] addr = 64'hDEAD_BEEF_0000_17C5;
        bit ok = 1;
        for (int k = 0; k < NB; k++) wblk[k*DW +: DW] = 64'(8'hA0 + k);
        run_txn(1, 0, addr, wblk, '0, 0, 0, 0, 1, 2, 0);
        checks++;
        if (obs_wdata.size() != NB) ok = 0;
        else for (int i = 0; i < NB; i++)
            if (obs_wdata[i] !== 64'(8'hA0 + i) || obs_wlast[i] != (i == NB - 1)) ok = 0;
        if (!ok) begin
            errors++;
            $display("FAIL write_basic_beats: got %0d beats (first %h) expected 8 beats A0..A7, wlast only on A7",
                     obs_wdata.size(), (obs_wdata.size() > 0) ? obs_wdata[0] : 64'hx);
        end
        checks++;
        if (!obs_done || obs_done_cyc != obs_bvalid_cyc + 1) begin
            errors++;
            $display("FAIL write_basic_done: got done=%0d cycle=%0d expected cycle %0d", obs_done, obs_done_cyc, obs_bvalid_cyc + 1);
        end
        checks++;
        if (obs_awaddr !== align(addr) || obs_aw_unstable) begin
            errors++;
            $display("FAIL write_basic_awaddr: got %h expected %h", obs_awaddr, align(addr));
        end
        checks++;
        if (o_data_block !== model_rblk) begin
            errors++;
            $display("FAIL write_keeps_refill: got %h expected %h", o_data_block, model_rblk);
        end
    endtask

    task automatic test_priority();
        logic [BW-1:0] wblk = rand_block();
        bit ok = 1;
        run_txn(1, 1, 64'h8000, wblk, '0, 0, 1, 0, 0, 0, 0);
        checks++;
        if (!obs_done || obs_first_ar != 0 || obs_first_aw == 0) begin
            errors++;
            $display("FAIL priority_order: got done=%0d first_ar=%0d first_aw=%0d expected AW only",
                     obs_done, obs_first_ar, obs_first_aw);
        end
        checks++;
        if (obs_wdata.size() != NB) ok = 0;
        else for (int i = 0; i < NB; i++) if (obs_wdata[i] !== wblk[i*DW +: DW]) ok = 0;
        if (!ok) begin
            errors++;
            $display("FAIL priority_wdata: got %0d beats expected %0d matching block", obs_wdata.size(), NB);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (o_arvalid !== 1'b0) begin
            errors++;
            $display("FAIL priority_no_ar: got arvalid=%b expected 0", o_arvalid);
        end
    endtask

    task automatic test_ar_stall();
        logic [BW-1:0] rblk = rand_block();
        logic [AW-1:0] addr = 64'h0000_0042_0000_0FFF;
        run_txn(0, 1, addr, '0, rblk, 5, 0, 0, 0, 0, 0);
        model_rblk = rblk;
        checks++;
        if (obs_ar_unstable || obs_araddr !== align(addr) || obs_ar_cnt != 6) begin
            errors++;
            $display("FAIL ar_stall_stable: got unstable=%0d araddr=%h arvalid_cycles=%0d expected 0 %h 6",
                     obs_ar_unstable, obs_araddr, obs_ar_cnt, align(addr));
        end
        checks++;
        if (!obs_done || obs_done_cyc != 15 || o_data_block !== model_rblk) begin
            errors++;
            $display("FAIL ar_stall_read: got done=%0d cycle=%0d expected cycle 15 and block match", obs_done, obs_done_cyc);
        end
    endtask

    task automatic test_mid_reset();
        logic [BW-1:0] rblk = rand_block();
        run_txn(0, 1, 64'h4440, '0, rblk, 0, 0, 0, 0, 0, 4);
        checks++;
        if (!obs_aborted) begin
            errors++;
            $display("FAIL mid_reset_reach: got no beat 3 handshake expected one");
        end
        i_arst = 1'b1;
        model_rblk = '0;
        @(negedge clk);
        checks++;
        if ({o_arvalid, o_rready, o_awvalid, o_wvalid, o_wlast, o_bready, o_axi_done} !== 7'b0 ||
            o_araddr !== '0 || o_awaddr !== '0 || o_wdata !== '0) begin
            errors++;
            $display("FAIL mid_reset_ctrl: got ctrl=%b araddr=%h expected all 0",
                     {o_arvalid, o_rready, o_awvalid, o_wvalid, o_wlast, o_bready, o_axi_done}, o_araddr);
        end
        checks++;
        if (o_data_block !== '0) begin
            errors++;
            $display("FAIL mid_reset_block: got %h expected 0", o_data_block);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (o_arvalid !== 1'b0 || o_awvalid !== 1'b0) begin
                errors++;
                $display("FAIL reset_holds_idle: got arvalid=%b awvalid=%b expected 0", o_arvalid, o_awvalid);
            end
        end
        idle_inputs();
        i_arst = 1'b0;
        rblk = rand_block();
        run_txn(0, 1, 64'h7777, '0, rblk, 0, 0, 0, 0, 0, 0);
        model_rblk = rblk;
        checks++;
        if (!obs_done || obs_done_cyc != 10 || o_data_block !== model_rblk) begin
            errors++;
            $display("FAIL mid_reset_recover: got done=%0d cycle=%0d expected cycle 10 and block match", obs_done, obs_done_cyc);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            logic [BW-1:0] rblk = rand_block();
            logic [BW-1:0] wblk = rand_block();
            logic [AW-1:0] addr = {$urandom(), $urandom()};
            bit ok = 1;
            run_txn(0, 1, addr, '0, rblk, $urandom_range(0, 3), 0, 1, 0, 0, 0);
            model_rblk = rblk;
            checks++;
            if (!obs_done || o_data_block !== model_rblk || obs_araddr !== align(addr)) begin
                errors++;
                $display("FAIL rand_read[%0d]: got done=%0d araddr=%h block=%h expected %h %h",
                         it, obs_done, obs_araddr, o_data_block, align(addr), model_rblk);
            end
            addr = {$urandom(), $urandom()};
            run_txn(1, 0, addr, wblk, '0, 0, $urandom_range(0, 3), 0, 2, $urandom_range(0, 3), 0);
            checks++;
            if (obs_wdata.size() != NB) ok = 0;
            else for (int i = 0; i < NB; i++)
                if (obs_wdata[i] !== wblk[i*DW +: DW] || obs_wlast[i] != (i == NB - 1)) ok = 0;
            if (!ok || !obs_done || obs_done_cyc != obs_bvalid_cyc + 1 || obs_awaddr !== align(addr)) begin
                errors++;
                $display("FAIL rand_write[%0d]: got beats=%0d done=%0d awaddr=%h expected 8 beats, done, %h",
                         it, obs_wdata.size(), obs_done, obs_awaddr, align(addr));
            end
        end
    endtask

`ifdef BLOCK_AXI_BRIDGE_RESP_CHECK_EN
    task automatic test_resp_check();
        logic [BW-1:0] rblk = rand_block();
        err_beat = 5;
        run_txn(0, 1, 64'h100, '0, rblk, 0, 0, 0, 0, 0, 0);
        model_rblk = rblk;
        checks++;
        if (!obs_done || obs_err !== 1'b1) begin
            errors++;
            $display("FAIL resp_error: got done=%0d error=%b expected 1 1", obs_done, obs_err);
        end
        err_beat = -1;
        run_txn(0, 1, 64'h200, '0, rblk, 0, 0, 1, 0, 0, 0);
        checks++;
        if (!obs_done || obs_err !== 1'b0) begin
            errors++;
            $display("FAIL resp_clean: got done=%0d error=%b expected 1 0", obs_done, obs_err);
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_read_basic();
        test_write_basic();
        test_priority();
        test_ar_stall();
        test_mid_reset();
        test_random();
`ifdef BLOCK_AXI_BRIDGE_RESP_CHECK_EN
        test_resp_check();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
